ahb_slave_mem: RTL and testbench
================================

Name: ahb_slave_mem

Overview:
Synthesizable AHB-lite slave responder: the target end of the miniTB AHB master bus functional model. It accepts NONSEQ/SEQ transfers, stores write data in an internal word memory, and returns read data. It inserts a programmable number of wait states via hready. Benches instantiate it as the default memory target behind the master BFM.

Parameters:
addrWidth, 8, address width; memory depth is 2**addrWidth words, indexed directly by haddr.
dataWidth, 32, data bus width.
WAIT_STATES, 0, hready-low cycles inserted in each data phase (0..15).

Ports:
hclk  input  1  bus clock; all logic on posedge.
hreset  input  1  synchronous, active-high reset.
htrans  input  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
haddr  input  addrWidth  word address.
hwrite  input  1  1=write, 0=read.
hwdata  input  dataWidth  write data, valid in the data phase.
hready  output  1  transfer-done / accept indicator.
hrdata  output  dataWidth  read data, valid when hready=1 in a read data phase.

Behaviour:
- One clock (hclk). Reset is synchronous and active-high (hreset). On reset: state=IDLE, hready=1, hrdata=0, wait counter=0, captured address/control cleared. Memory contents are not cleared.
- Address-phase capture:
  - On a posedge with hready=1 and htrans[1]=1 (NONSEQ or SEQ), latch haddr and hwrite, then enter the data phase.
  - BUSY and IDLE are not captured. Any data phase they would create gets a zero-wait OKAY.
- State machine:
  - IDLE -> (capture, WAIT_STATES=0) -> DATA.
  - IDLE -> (capture, WAIT_STATES>0) -> WAIT.
  - WAIT: hready=0; counter counts down from WAIT_STATES; on reaching 1, -> DATA.
  - DATA: hready=1. If a new transfer is captured at the closing edge, reload -> WAIT or DATA. Otherwise -> IDLE.
- hready is 1 in IDLE and DATA, 0 in WAIT.
- Latency: with WAIT_STATES=N, each data phase lasts N+1 cycles. Back-to-back pipelined transfers sustain one transfer per N+1 cycles.
- Write commit: mem[addr_q] <= hwdata at the posedge ending the data phase (DATA state).
- Read:
  - hrdata is registered. It is loaded with mem[addr_q] on the edge entering DATA and held until the next read data phase completes.
  - hrdata holds its last value outside read data phases.
- Forwarding: if a write commits to address A on the same edge that loads hrdata for a read of A, hrdata takes hwdata (the new value).
- Reset mid-transfer: an uncommitted write is discarded. The next cycle is IDLE with hready=1.
- Address wrap: none needed; haddr covers the memory exactly.

Optional Feature:
AHB_SLAVE_ERR_RESP_EN.
- When defined: adds output hresp (1 bit, 0=OKAY, 1=ERROR, reset 0) and parameter ERR_ADDR_BASE (default 2**addrWidth-16).
- A transfer with addr_q >= ERR_ADDR_BASE gets the two-cycle ERROR response:
  - cycle 1: hready=0, hresp=1;
  - cycle 2: hready=1, hresp=1.
  - Wait states are inserted before cycle 1.
- An ERROR write does not modify memory. An ERROR read leaves hrdata unchanged.
- When undefined: no hresp port; every address responds OKAY.

Decomposition:
- Package ahb_pkg: htrans_t enum (IDLE/BUSY/NONSEQ/SEQ), hresp constants OKAY/ERROR, slave state_t enum (IDLE/WAIT/DATA/ERR1/ERR2).
- Natural sub-module: ahb_slave_mem_array. It holds the storage with one synchronous write port, one registered read port, and same-address write-to-read forwarding.

Test Plan:
- WAIT_STATES=0: write 0x10 <- 0xDEADBEEF, then read 0x10 -> hready never low; hrdata=0xDEADBEEF in the read data phase.
- Pipelined write 0x20 <- 0x12345678 immediately followed by read 0x20 -> forwarded hrdata=0x12345678 with no stall.
- WAIT_STATES=3: single write -> hready low exactly 3 cycles, then high 1 cycle; memory updated only after the high cycle.
- Reset asserted during the WAIT cycle of a write to 0x30 (old 0x0) -> hready=1 and hrdata=0 the next cycle; a later read of 0x30 returns 0x0.
- htrans=BUSY with haddr=0x40, hwrite=1, hwdata=0xFFFFFFFF -> no memory change; hready stays 1.
- AHB_SLAVE_ERR_RESP_EN, write to 0xF5 -> hresp=1 for two cycles with hready 0 then 1; a subsequent read of 0xF5 also returns ERROR, and hrdata keeps its previous value.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-lite types for the memory slave: transfer encodings, response
// constants and the slave sequencing states.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB-lite bus bundle between a master and the memory slave.
// hresp is present only when AHB_SLAVE_ERR_RESP_EN is defined.
interface ahb_slave_mem_if #(
    parameter int addrWidth = 8,
    parameter int dataWidth = 32
) ();

    logic [1:0]           htrans;
    logic [addrWidth-1:0] haddr;
    logic                 hwrite;
    logic [dataWidth-1:0] hwdata;
    logic                 hready;
    logic [dataWidth-1:0] hrdata;
`ifdef AHB_SLAVE_ERR_RESP_EN
    logic                 hresp;
`endif

    modport master (
        output htrans, haddr, hwrite, hwdata,
        input  hready, hrdata
`ifdef AHB_SLAVE_ERR_RESP_EN
        , input hresp
`endif
    );

    modport slave (
        input  htrans, haddr, hwrite, hwdata,
        output hready, hrdata
`ifdef AHB_SLAVE_ERR_RESP_EN
        , output hresp
`endif
    );

endinterface

// File: rtl/ahb_slave_mem_array.sv
// Word storage for the AHB memory slave: one synchronous write port and one
// registered read port. A read and write to the same word on the same edge
// returns the new write data.
module ahb_slave_mem_array #(
    parameter int addrWidth = 8,
    parameter int dataWidth = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [addrWidth-1:0] waddr,
    input  logic [dataWidth-1:0] wdata,
    input  logic                 re,
    input  logic [addrWidth-1:0] raddr,
    output logic [dataWidth-1:0] rdata
);

    logic [dataWidth-1:0] mem [2**addrWidth];

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read with same-address write forwarding.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-lite memory slave: captures NONSEQ/SEQ address phases, inserts
// WAIT_STATES hready-low cycles per data phase, commits writes at the end of
// the data phase and returns registered read data.
// Optional macro AHB_SLAVE_ERR_RESP_EN adds hresp and a two-cycle ERROR
// response for addresses at or above ERR_ADDR_BASE.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int addrWidth   = 8,
    parameter int dataWidth   = 32,
    parameter int WAIT_STATES = 0
`ifdef AHB_SLAVE_ERR_RESP_EN
    , parameter int ERR_ADDR_BASE = 2**addrWidth - 16
`endif
) (
    input  logic          hclk,
    input  logic          hreset,
    ahb_slave_mem_if.slave bus
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    state_t               state;
    logic [3:0]           wait_cnt;
    logic [addrWidth-1:0] addr_q;
    logic                 write_q;
    logic                 ready_q;

    logic                 capture;
    logic                 cap_err;
    logic                 q_err;
    logic                 mem_we;
    logic                 mem_re;
    logic [addrWidth-1:0] mem_raddr;
    logic [dataWidth-1:0] mem_rdata;

`ifdef AHB_SLAVE_ERR_RESP_EN
    localparam logic [addrWidth-1:0] ERR_BASE = addrWidth'(ERR_ADDR_BASE);
    logic hresp_q;

    assign cap_err  = (bus.haddr >= ERR_BASE);
    assign q_err    = (addr_q >= ERR_BASE);
    assign bus.hresp = hresp_q;
`else
    assign cap_err = 1'b0;
    assign q_err   = 1'b0;
`endif

    assign bus.hready = ready_q;
    assign bus.hrdata = mem_rdata;

    // Address-phase capture and memory port control.
    always_comb begin
        capture   = ready_q && ((bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ));
        mem_we    = !hreset && (state == ST_DATA) && write_q;
        mem_re    = 1'b0;
        mem_raddr = addr_q;
        if (!hreset) begin
            if (capture && !bus.hwrite && (WAIT_LOAD == '0) && !cap_err) begin
                mem_re    = 1'b1;
                mem_raddr = bus.haddr;
            end else if ((state == ST_WAIT) && (wait_cnt == 4'd1) && !write_q && !q_err) begin
                mem_re = 1'b1;
            end
        end
    end

    // Transfer sequencing with registered hready.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state    <= ST_IDLE;
            ready_q  <= 1'b1;
            wait_cnt <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == 4'd1) begin
                        wait_cnt <= '0;
                        if (q_err) begin
                            state   <= ST_ERR1;
                            ready_q <= 1'b0;
                        end else begin
                            state   <= ST_DATA;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state   <= ST_ERR2;
                    ready_q <= 1'b1;
                end
                default: begin
                    // IDLE, DATA and ERR2 all accept a new address phase.
                    if (capture) begin
                        addr_q  <= bus.haddr;
                        write_q <= bus.hwrite;
                        if (WAIT_LOAD != '0) begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                            ready_q  <= 1'b0;
                        end else if (cap_err) begin
                            state   <= ST_ERR1;
                            ready_q <= 1'b0;
                        end else begin
                            state   <= ST_DATA;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef AHB_SLAVE_ERR_RESP_EN
    // hresp is high for exactly the ERR1/ERR2 cycles, registered alongside state.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            hresp_q <= HRESP_OKAY;
        end else if (state == ST_ERR1) begin
            hresp_q <= HRESP_ERROR;
        end else if (state == ST_WAIT) begin
            hresp_q <= ((wait_cnt == 4'd1) && q_err) ? HRESP_ERROR : HRESP_OKAY;
        end else begin
            hresp_q <= (capture && (WAIT_LOAD == '0) && cap_err) ? HRESP_ERROR : HRESP_OKAY;
        end
    end
`endif

    ahb_slave_mem_array #(
        .addrWidth(addrWidth),
        .dataWidth(dataWidth)
    ) u_array (
        .clk  (hclk),
        .rst  (hreset),
        .we   (mem_we),
        .waddr(addr_q),
        .wdata(bus.hwdata),
        .re   (mem_re),
        .raddr(mem_raddr),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Self-checking bench for ahb_slave_mem: two instances (0 and 3 wait states)
// driven by a pipelined master task and checked against a word-array model.
module tb_ahb_slave_mem;
    import ahb_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;

    typedef struct {
        logic [1:0]  trans;
        logic [7:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_d [2];
    logic [1:0]  htr   [2];
    logic [7:0]  ha    [2];
    logic        hw    [2];
    logic [31:0] hwd   [2];
    logic        hrdy  [2];
    logic [31:0] hrd   [2];
`ifdef AHB_SLAVE_ERR_RESP_EN
    logic        hrsp  [2];
`endif

    ahb_slave_mem_if #(.addrWidth(AW), .dataWidth(DW)) bus0 ();
    ahb_slave_mem_if #(.addrWidth(AW), .dataWidth(DW)) bus3 ();

    assign bus0.htrans = htr[0];
    assign bus0.haddr  = ha[0];
    assign bus0.hwrite = hw[0];
    assign bus0.hwdata = hwd[0];
    assign hrdy[0]     = bus0.hready;
    assign hrd[0]      = bus0.hrdata;
    assign bus3.htrans = htr[1];
    assign bus3.haddr  = ha[1];
    assign bus3.hwrite = hw[1];
    assign bus3.hwdata = hwd[1];
    assign hrdy[1]     = bus3.hready;
    assign hrd[1]      = bus3.hrdata;
`ifdef AHB_SLAVE_ERR_RESP_EN
    assign hrsp[0]     = bus0.hresp;
    assign hrsp[1]     = bus3.hresp;
`endif

    ahb_slave_mem #(.addrWidth(AW), .dataWidth(DW), .WAIT_STATES(0)) dut0 (
        .hclk(clk), .hreset(rst_d[0]), .bus(bus0)
    );
    ahb_slave_mem #(.addrWidth(AW), .dataWidth(DW), .WAIT_STATES(3)) dut3 (
        .hclk(clk), .hreset(rst_d[1]), .bus(bus3)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] mdl [2][256];
    logic [31:0] last_rd [2];
    vec_t        pend[$];
    logic [31:0] rd_res[$];
    vec_t        tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_err(input logic [7:0] a);
`ifdef AHB_SLAVE_ERR_RESP_EN
        return a >= 8'hF0;
`else
        return (a != a);
`endif
    endfunction

    function automatic vec_t mk(input logic [1:0] t, input logic [7:0] a, input logic w,
                                input logic [31:0] wd, input logic [31:0] e);
        vec_t v;
        v.trans = t; v.addr = a; v.wr = w; v.wdata = wd; v.exp = e;
        return v;
    endfunction

    // Pipelined master: plays pend[] into DUT d; each data phase must last
    // WAIT_STATES+1 cycles (+1 for ERROR), reads must match the model.
    task automatic run(input int d);
        int   n;
        vec_t ap, dp;
        bit   ap_v, dp_v, done_now, cap, rdy_s;
        int   dpc, lat, cyc;
        n = (d == 0) ? 0 : 3;
        ap_v = 0; dp_v = 0; dpc = 0; lat = 0; cyc = 0;
        while (ap_v || dp_v || (pend.size() > 0)) begin
            if (!ap_v && (pend.size() > 0)) begin
                ap = pend.pop_front();
                ap_v = 1;
            end
            if (ap_v) begin
                htr[d] = ap.trans; ha[d] = ap.addr; hw[d] = ap.wr;
                if (!ap.trans[1] && !dp_v) hwd[d] = ap.wdata;
            end else begin
                htr[d] = HTRANS_IDLE;
            end
            @(negedge clk);
            rdy_s = hrdy[d];
            done_now = 0;
            if (dp_v) begin
                dpc++;
                check("hready_dp", 32'(rdy_s), 32'(dpc == lat));
`ifdef AHB_SLAVE_ERR_RESP_EN
                check("hresp_dp", 32'(hrsp[d]), 32'(is_err(dp.addr) && (dpc > n)));
`endif
                if (rdy_s) begin
                    done_now = 1;
                    if (dp.wr) begin
                        if (!is_err(dp.addr)) mdl[d][dp.addr] = dp.wdata;
                    end else begin
                        if (!is_err(dp.addr)) last_rd[d] = mdl[d][dp.addr];
                        check("hrdata", hrd[d], last_rd[d]);
                        rd_res.push_back(hrd[d]);
                    end
                end else if (dpc > lat + 8) begin
                    checks++; failures++;
                    $display("FAIL hready_timeout: hready still 0 after %0d cycles, required %0d", dpc, lat);
                    pend.delete();
                    htr[d] = HTRANS_IDLE;
                    return;
                end
            end else begin
                check("hready_idle", 32'(rdy_s), 32'd1);
`ifdef AHB_SLAVE_ERR_RESP_EN
                check("hresp_idle", 32'(hrsp[d]), 32'd0);
`endif
            end
            cap = rdy_s && ap_v && ap.trans[1];
            @(posedge clk); #1;
            if (done_now) dp_v = 0;
            if (cap) begin
                dp = ap; dp_v = 1; dpc = 0;
                lat = n + 1 + (is_err(ap.addr) ? 1 : 0);
                hwd[d] = ap.wdata;
            end
            if (rdy_s && ap_v) ap_v = 0;
            cyc++;
            if (cyc > 20000) begin
                checks++; failures++;
                $display("FAIL cycle_budget: got %0d cycles required < 20000", cyc);
                pend.delete();
                htr[d] = HTRANS_IDLE;
                return;
            end
        end
        htr[d] = HTRANS_IDLE;
    endtask

    initial begin
        vec_t v;
        logic [31:0] got;
        int r;

        // Directed vectors: read entries carry their expected hrdata.
        tbl.push_back(mk(HTRANS_NONSEQ, 8'h10, 1'b1, 32'hDEADBEEF, 32'h0));
        tbl.push_back(mk(HTRANS_NONSEQ, 8'h10, 1'b0, 32'h0,        32'hDEADBEEF));
        tbl.push_back(mk(HTRANS_NONSEQ, 8'h20, 1'b1, 32'h12345678, 32'h0));
        tbl.push_back(mk(HTRANS_SEQ,    8'h20, 1'b0, 32'h0,        32'h12345678));
        tbl.push_back(mk(HTRANS_NONSEQ, 8'h40, 1'b1, 32'h0BADF00D, 32'h0));
        tbl.push_back(mk(HTRANS_IDLE,   8'h00, 1'b0, 32'h0,        32'h0));
        tbl.push_back(mk(HTRANS_BUSY,   8'h40, 1'b1, 32'hFFFFFFFF, 32'h0));
        tbl.push_back(mk(HTRANS_NONSEQ, 8'h40, 1'b0, 32'h0,        32'h0BADF00D));
`ifdef AHB_SLAVE_ERR_RESP_EN
        tbl.push_back(mk(HTRANS_NONSEQ, 8'hF5, 1'b1, 32'hCAFEF00D, 32'h0));
        tbl.push_back(mk(HTRANS_NONSEQ, 8'hF5, 1'b0, 32'h0,        32'h0BADF00D));
`endif

        for (int d = 0; d < 2; d++) begin
            rst_d[d] = 1'b1; htr[d] = HTRANS_IDLE; ha[d] = '0; hw[d] = 1'b0; hwd[d] = '0;
            last_rd[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_d[0] = 1'b0; rst_d[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_hready", 32'(hrdy[d]), 32'd1);
            check("reset_hrdata", hrd[d], 32'd0);
`ifdef AHB_SLAVE_ERR_RESP_EN
            check("reset_hresp", 32'(hrsp[d]), 32'd0);
`endif
        end
        @(posedge clk); #1;

        for (int d = 0; d < 2; d++) begin
            rd_res.delete();
            for (int i = 0; i < tbl.size(); i++) pend.push_back(tbl[i]);
            run(d);
            for (int i = 0; i < tbl.size(); i++) begin
                if (tbl[i].trans[1] && !tbl[i].wr) begin
                    if (rd_res.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL tbl_rd[%0d]: no read result, required %h", i, tbl[i].exp);
                    end else begin
                        got = rd_res.pop_front();
                        check($sformatf("tbl_rd[%0d]", i), got, tbl[i].exp);
                    end
                end
            end

            // Fill every word so random reads always have a known value.
            for (int a = 0; a < 256; a++) pend.push_back(mk(HTRANS_NONSEQ, 8'(a), 1'b1, $urandom, 32'h0));
            run(d);

            for (int i = 0; i < 300; i++) begin
                r = $urandom_range(0, 9);
                v.trans = (r == 0) ? HTRANS_BUSY : (r == 1) ? HTRANS_IDLE :
                          (r < 6) ? HTRANS_NONSEQ : HTRANS_SEQ;
                v.addr  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
                v.wr    = ($urandom_range(0, 1) != 0);
                v.wdata = $urandom;
                v.exp   = '0;
                pend.push_back(v);
            end
            run(d);
            rd_res.delete();
        end

        // Reset in the wait state of a write to 0x30 discards the write.
        pend.push_back(mk(HTRANS_NONSEQ, 8'h30, 1'b1, 32'h0, 32'h0));
        run(1);
        htr[1] = HTRANS_NONSEQ; ha[1] = 8'h30; hw[1] = 1'b1;
        @(negedge clk);
        check("rst_seq_accept", 32'(hrdy[1]), 32'd1);
        @(posedge clk); #1;
        htr[1] = HTRANS_IDLE; hwd[1] = 32'hA5A5A5A5;
        @(negedge clk);
        check("rst_seq_wait", 32'(hrdy[1]), 32'd0);
        rst_d[1] = 1'b1;
        @(posedge clk); #1;
        rst_d[1] = 1'b0;
        @(negedge clk);
        check("rst_seq_hready", 32'(hrdy[1]), 32'd1);
        check("rst_seq_hrdata", hrd[1], 32'd0);
        last_rd[1] = '0;
        @(posedge clk); #1;
        rd_res.delete();
        pend.push_back(mk(HTRANS_NONSEQ, 8'h30, 1'b0, 32'h0, 32'h0));
        run(1);
        if (rd_res.size() == 0) begin
            checks++; failures++;
            $display("FAIL rst_seq_read: no read result, required 00000000");
        end else begin
            got = rd_res.pop_front();
            check("rst_seq_read", got, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
